dma_sram_sequencer: RTL and testbench

//  Parametrised DMA-to-SRAM sequencer for the LeNet accelerator wrapper, replacing the fixed 64-bit loader.

---
 rtl/dma_sram_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_dma_sram_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sram_sequencer.sv
// dma_sram_sequencer: five-phase DMA<->SRAM sequencer (weights, IFM, compute, OFM store, done).
// Define WGT_CACHE_EN to add cfg_wgt_reload and skip reloading weights that are already resident.
module dma_sram_sequencer #(
  parameter int WORD_W = 32,
  parameter int LANES = 2,
  parameter int ADDR_W = 16,
  parameter int LEN_W = 16,
  parameter logic [2:0] DMA_SIZE = 3'b010
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      conf_done,
  input  logic [31:0]               cfg_wgt_index,
  input  logic [LEN_W-1:0]          cfg_wgt_len,
  input  logic [31:0]               cfg_ifm_index,
  input  logic [LEN_W-1:0]          cfg_ifm_len,
  input  logic [31:0]               cfg_ofm_index,
  input  logic [LEN_W-1:0]          cfg_ofm_len,
  input  logic [ADDR_W-1:0]         cfg_ofm_base,
`ifdef WGT_CACHE_EN
  input  logic                      cfg_wgt_reload,
`endif
  output logic                      dma_read_ctrl_valid,
  input  logic                      dma_read_ctrl_ready,
  output logic [31:0]               dma_read_ctrl_index,
  output logic [31:0]               dma_read_ctrl_length,
  output logic [2:0]                dma_read_ctrl_size,
  input  logic                      dma_read_chnl_valid,
  output logic                      dma_read_chnl_ready,
  input  logic [WORD_W*LANES-1:0]   dma_read_chnl_data,
  output logic                      dma_write_ctrl_valid,
  input  logic                      dma_write_ctrl_ready,
  output logic [31:0]               dma_write_ctrl_index,
  output logic [31:0]               dma_write_ctrl_length,
  output logic [2:0]                dma_write_ctrl_size,
  output logic                      dma_write_chnl_valid,
  input  logic                      dma_write_chnl_ready,
  output logic [WORD_W*LANES-1:0]   dma_write_chnl_data,
  output logic [LANES-1:0]          wgt_we,
  output logic [LANES*ADDR_W-1:0]   wgt_addr,
  output logic [WORD_W*LANES-1:0]   wgt_wdata,
  output logic [LANES-1:0]          act_we,
  output logic [LANES*ADDR_W-1:0]   act_addr,
  output logic [WORD_W*LANES-1:0]   act_wdata,
  input  logic [WORD_W*LANES-1:0]   act_rdata,
  input  logic [LANES-1:0]          eng_act_we,
  input  logic [LANES*ADDR_W-1:0]   eng_act_addr,
  input  logic [WORD_W*LANES-1:0]   eng_act_wdata,
  output logic                      compute_start,
  input  logic                      compute_finish,
  output logic                      acc_done,
  output logic [31:0]               debug
);
  typedef enum logic [3:0] {
    IDLE, WGT_CTRL, WGT_DATA, IFM_CTRL, IFM_DATA, COMPUTE, OFM_CTRL, OFM_DATA, DONE
  } state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] beat_cnt, rd_cnt, len_cur;
  logic [LANES*ADDR_W-1:0] lane_addr;
  logic [WORD_W*LANES-1:0] sk0, sk1;
  logic [1:0] cnt, occ, wi;
  logic inflight, pop, rd_issue, load_beat, last, skip_wgt, is_ctrl;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_addr[i*ADDR_W+:ADDR_W] = addr + ADDR_W'(i);
  end
  assign len_cur = (state == WGT_DATA) ? cfg_wgt_len : (state == IFM_DATA) ? cfg_ifm_len : cfg_ofm_len;
  assign last = beat_cnt == len_cur - LEN_W'(1);
  assign is_ctrl = state inside {WGT_CTRL, IFM_CTRL, OFM_CTRL};
  assign load_beat = rst && (state == WGT_DATA || state == IFM_DATA) && dma_read_chnl_valid;
  assign dma_write_chnl_valid = rst && state == OFM_DATA && cnt != 2'd0;
  assign dma_write_chnl_data = dma_write_chnl_valid ? sk0 : '0;
  assign pop = dma_write_chnl_valid && dma_write_chnl_ready;
  // occupancy after this cycle's pop plus the read landing now; a read only issues if it will fit
  assign wi = cnt - {1'b0, pop};
  assign occ = wi + {1'b0, inflight};
  assign rd_issue = rst && state == OFM_DATA && rd_cnt != cfg_ofm_len && occ < 2'd2;
  assign compute_start = rst && state == COMPUTE;
  assign acc_done = rst && state == DONE;
  assign debug = {state, 12'b0, 16'(beat_cnt)};
`ifdef WGT_CACHE_EN
  logic wgt_loaded;
  always_ff @(posedge clk)
    if (!rst) wgt_loaded <= 1'b0;
    else if (state == WGT_DATA && load_beat && last) wgt_loaded <= 1'b1;
  assign skip_wgt = cfg_wgt_len == '0 || (wgt_loaded && !cfg_wgt_reload);
`else
  assign skip_wgt = cfg_wgt_len == '0;
`endif
  always_comb begin
    state_n = state;
    dma_read_ctrl_valid = 1'b0;
    dma_read_ctrl_index = '0;
    dma_read_ctrl_length = '0;
    dma_read_ctrl_size = '0;
    dma_write_ctrl_valid = 1'b0;
    dma_write_ctrl_index = '0;
    dma_write_ctrl_length = '0;
    dma_write_ctrl_size = '0;
    dma_read_chnl_ready = 1'b0;
    wgt_we = '0;
    wgt_addr = '0;
    wgt_wdata = '0;
    act_we = '0;
    act_addr = '0;
    act_wdata = '0;
    if (rst)
      case (state)
        IDLE: state_n = conf_done ? WGT_CTRL : IDLE;
        WGT_CTRL: begin
          dma_read_ctrl_valid = !skip_wgt;
          dma_read_ctrl_index = skip_wgt ? '0 : cfg_wgt_index;
          dma_read_ctrl_length = skip_wgt ? '0 : 32'(cfg_wgt_len);
          dma_read_ctrl_size = skip_wgt ? '0 : DMA_SIZE;
          state_n = skip_wgt ? IFM_CTRL : dma_read_ctrl_ready ? WGT_DATA : WGT_CTRL;
        end
        WGT_DATA: begin
          dma_read_chnl_ready = 1'b1;
          wgt_we = {LANES{dma_read_chnl_valid}};
          wgt_addr = lane_addr;
          wgt_wdata = dma_read_chnl_valid ? dma_read_chnl_data : '0;
          state_n = load_beat && last ? IFM_CTRL : WGT_DATA;
        end
        IFM_CTRL: begin
          dma_read_ctrl_valid = cfg_ifm_len != '0;
          dma_read_ctrl_index = dma_read_ctrl_valid ? cfg_ifm_index : '0;
          dma_read_ctrl_length = dma_read_ctrl_valid ? 32'(cfg_ifm_len) : '0;
          dma_read_ctrl_size = dma_read_ctrl_valid ? DMA_SIZE : '0;
          state_n = !dma_read_ctrl_valid ? COMPUTE : dma_read_ctrl_ready ? IFM_DATA : IFM_CTRL;
        end
        IFM_DATA: begin
          dma_read_chnl_ready = 1'b1;
          act_we = {LANES{dma_read_chnl_valid}};
          act_addr = lane_addr;
          act_wdata = dma_read_chnl_valid ? dma_read_chnl_data : '0;
          state_n = load_beat && last ? COMPUTE : IFM_DATA;
        end
        COMPUTE: begin
          act_we = eng_act_we;
          act_addr = eng_act_addr;
          act_wdata = eng_act_wdata;
          state_n = compute_finish ? OFM_CTRL : COMPUTE;
        end
        OFM_CTRL: begin
          dma_write_ctrl_valid = cfg_ofm_len != '0;
          dma_write_ctrl_index = dma_write_ctrl_valid ? cfg_ofm_index : '0;
          dma_write_ctrl_length = dma_write_ctrl_valid ? 32'(cfg_ofm_len) : '0;
          dma_write_ctrl_size = dma_write_ctrl_valid ? DMA_SIZE : '0;
          state_n = !dma_write_ctrl_valid ? DONE : dma_write_ctrl_ready ? OFM_DATA : OFM_CTRL;
        end
        OFM_DATA: begin
          act_addr = lane_addr;
          state_n = pop && last ? DONE : OFM_DATA;
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      beat_cnt <= '0;
      rd_cnt <= '0;
      inflight <= 1'b0;
      cnt <= '0;
      sk0 <= '0;
      sk1 <= '0;
    end else begin
      state <= state_n;
      inflight <= rd_issue;
      cnt <= occ;
      sk0 <= (inflight && wi == 2'd0) ? act_rdata : pop ? sk1 : sk0;
      sk1 <= (inflight && wi == 2'd1) ? act_rdata : sk1;
      if (is_ctrl) begin
        addr <= (state == OFM_CTRL) ? cfg_ofm_base : '0;
        beat_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        if (load_beat || rd_issue) addr <= addr + ADDR_W'(LANES);
        if (load_beat || pop) beat_cnt <= beat_cnt + LEN_W'(1);
        if (rd_issue) rd_cnt <= rd_cnt + LEN_W'(1);
      end
    end
endmodule

// File: tb/tb_dma_sram_sequencer.sv
// tb_dma_sram_sequencer: scoreboard bench with DMA, SRAM and engine models around dma_sram_sequencer.
module tb_dma_sram_sequencer;
  localparam logic [31:0] WGT_IDX = 32'h100, IFM_IDX = 32'h200, OFM_IDX = 32'h300;
  typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
  logic clk = 0, rst = 0, conf_done = 0, cfg_wgt_reload = 1;
  logic [15:0] cfg_wgt_len = 0, cfg_ifm_len = 0, cfg_ofm_len = 0, cfg_ofm_base = 0;
  logic dma_read_ctrl_valid, dma_read_ctrl_ready = 1, dma_read_chnl_valid = 0, dma_read_chnl_ready;
  logic [31:0] dma_read_ctrl_index, dma_read_ctrl_length, dma_write_ctrl_index, dma_write_ctrl_length;
  logic [2:0] dma_read_ctrl_size, dma_write_ctrl_size;
  logic [63:0] dma_read_chnl_data = 0, dma_write_chnl_data, wgt_wdata, act_wdata, act_rdata = 0;
  logic dma_write_ctrl_valid, dma_write_ctrl_ready = 1, dma_write_chnl_valid, dma_write_chnl_ready = 1;
  logic [1:0] wgt_we, act_we;
  logic [31:0] wgt_addr, act_addr, debug;
  logic [1:0] eng_act_we = 0;
  logic [31:0] eng_act_addr = 32'h0055_0054;
  logic [63:0] eng_act_wdata = 0;
  logic compute_start, compute_finish = 0, acc_done;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  dma_sram_sequencer dut (
    .clk(clk), .rst(rst), .conf_done(conf_done),
    .cfg_wgt_index(WGT_IDX), .cfg_wgt_len(cfg_wgt_len),
    .cfg_ifm_index(IFM_IDX), .cfg_ifm_len(cfg_ifm_len),
    .cfg_ofm_index(OFM_IDX), .cfg_ofm_len(cfg_ofm_len), .cfg_ofm_base(cfg_ofm_base),
`ifdef WGT_CACHE_EN
    .cfg_wgt_reload(cfg_wgt_reload),
`endif
    .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_ctrl_index(dma_read_ctrl_index), .dma_read_ctrl_length(dma_read_ctrl_length),
    .dma_read_ctrl_size(dma_read_ctrl_size),
    .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
    .dma_read_chnl_data(dma_read_chnl_data),
    .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
    .dma_write_ctrl_index(dma_write_ctrl_index), .dma_write_ctrl_length(dma_write_ctrl_length),
    .dma_write_ctrl_size(dma_write_ctrl_size),
    .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
    .dma_write_chnl_data(dma_write_chnl_data),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_wdata(wgt_wdata),
    .act_we(act_we), .act_addr(act_addr), .act_wdata(act_wdata), .act_rdata(act_rdata),
    .eng_act_we(eng_act_we), .eng_act_addr(eng_act_addr), .eng_act_wdata(eng_act_wdata),
    .compute_start(compute_start), .compute_finish(compute_finish), .acc_done(acc_done),
    .debug(debug)
  );

  // act SRAM model: one-cycle read latency, read-before-write
  logic [31:0] act_mem [0:1023];
  always @(posedge clk) begin
    logic [63:0] rd;
    for (int i = 0; i < 2; i++) rd[i*32+:32] = act_mem[act_addr[i*16+:10]];
    act_rdata <= rd;
    for (int i = 0; i < 2; i++) if (act_we[i]) act_mem[act_addr[i*16+:10]] = act_wdata[i*32+:32];
  end

  function automatic logic [31:0] rdword(logic [31:0] idx, int b, int i);
    return {idx[15:0], 16'(b * 2 + i)};
  endfunction

  // read DMA responder; pushes the SRAM writes each accepted beat must cause
  wr_t wgt_exp[$], wgt_obs[$], act_exp[$], act_obs[$];
  int rd_left = 0, rd_beat = 0;
  logic [31:0] rd_idx = 0;
  logic [15:0] exp_base = 0;
  always @(posedge clk) begin
    if (!rst) rd_left = 0;
    else if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
      rd_left = int'(dma_read_ctrl_length); rd_idx = dma_read_ctrl_index; rd_beat = 0; exp_base = 0;
    end else if (dma_read_chnl_valid && dma_read_chnl_ready) begin
      for (int i = 0; i < 2; i++)
        if (rd_idx == WGT_IDX) wgt_exp.push_back({exp_base + 16'(i), rdword(rd_idx, rd_beat, i)});
        else act_exp.push_back({exp_base + 16'(i), rdword(rd_idx, rd_beat, i)});
      exp_base += 16'd2; rd_left--; rd_beat++;
    end
    #1;
    dma_read_chnl_valid = rd_left > 0;
    dma_read_chnl_data = {rdword(rd_idx, rd_beat, 1), rdword(rd_idx, rd_beat, 0)};
  end

  int wr_mode = 0;
  logic wr_tog = 0;
  always @(posedge clk) begin
    #1; wr_tog = ~wr_tog; dma_write_chnl_ready = (wr_mode == 0) || wr_tog;
  end

  int comp_cyc = 0;
  always @(posedge clk) begin
    comp_cyc = compute_start ? comp_cyc + 1 : 0;
    #1; compute_finish = compute_start && comp_cyc == 10;
  end

  // monitor: observed writes/beats, OFM expectations from SRAM contents at store start
  logic [63:0] ofm_exp[$], ofm_obs[$], held_d;
  int ofm_cyc[$];
  int cyc = 0, acc_cnt = 0, rd_ctrl_vis = 0, wgt_hs = 0, stall_bad = 0, stall_seen = 0;
  int first_wv = -1, conf_cyc = 0, comp_first = -1;
  logic held_v = 0;
  logic [31:0] comp_addr = 0;
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (wgt_we[i]) wgt_obs.push_back({wgt_addr[i*16+:16], wgt_wdata[i*32+:32]});
      if (act_we[i] && !compute_start) act_obs.push_back({act_addr[i*16+:16], act_wdata[i*32+:32]});
    end
    if (acc_done) acc_cnt++;
    if (conf_done) conf_cyc = cyc;
    if (compute_start) comp_addr = act_addr;
    if (compute_start && comp_first < 0) comp_first = cyc;
    if (dma_read_ctrl_valid) rd_ctrl_vis++;
    if (dma_read_ctrl_valid && dma_read_ctrl_ready && dma_read_ctrl_index == WGT_IDX) wgt_hs++;
    if (dma_write_ctrl_valid && dma_write_ctrl_ready)
      for (int b = 0; b < int'(dma_write_ctrl_length); b++)
        ofm_exp.push_back({act_mem[10'(cfg_ofm_base) + 10'(2*b+1)], act_mem[10'(cfg_ofm_base) + 10'(2*b)]});
    if (dma_write_chnl_valid && first_wv < 0) first_wv = cyc;
    if (dma_write_chnl_valid && dma_write_chnl_ready) begin
      ofm_obs.push_back(dma_write_chnl_data); ofm_cyc.push_back(cyc);
    end
    if (held_v) begin
      stall_seen++;
      if (!dma_write_chnl_valid || dma_write_chnl_data !== held_d) stall_bad++;
    end
    held_v = dma_write_chnl_valid && !dma_write_chnl_ready;
    held_d = dma_write_chnl_data;
  end

  task automatic run_seq(input logic [15:0] wl, il, ol, base, output bit ok);
    int a0;
    cfg_wgt_len = wl; cfg_ifm_len = il; cfg_ofm_len = ol; cfg_ofm_base = base;
    wgt_exp.delete(); wgt_obs.delete(); act_exp.delete(); act_obs.delete();
    ofm_exp.delete(); ofm_obs.delete(); ofm_cyc.delete();
    first_wv = -1; comp_first = -1; a0 = acc_cnt;
    @(posedge clk); #1 conf_done = 1;
    @(posedge clk); #1 conf_done = 0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #2;
      ok = acc_cnt != a0;
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (3) @(posedge clk);
    #2;
    total++; if ({dma_read_ctrl_valid, dma_write_ctrl_valid, dma_write_chnl_valid, dma_read_chnl_ready} !== 4'b0)
      begin bad++; $display("FAIL reset_valids got=%b want=0", {dma_read_ctrl_valid, dma_write_ctrl_valid, dma_write_chnl_valid, dma_read_chnl_ready}); end
    total++; if ({wgt_we, act_we, compute_start, acc_done} !== 6'b0)
      begin bad++; $display("FAIL reset_strobes got=%b want=0", {wgt_we, act_we, compute_start, acc_done}); end
    total++; if (debug !== 32'h0) begin bad++; $display("FAIL reset_debug got=%h want=0", debug); end
    total++; if ({dma_write_chnl_data, wgt_wdata, act_wdata} !== '0) begin bad++; $display("FAIL reset_data got=nonzero want=0"); end
    rst = 1;
  endtask

  task automatic test_basic;
    bit ok; int a0 = acc_cnt; wr_t e, o; logic [63:0] eb, ob;
    for (int k = 0; k < 1024; k++) act_mem[k] = 32'hF000_0000 + k;
    run_seq(4, 2, 3, 0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_done got=%0d want=1", ok); end
    total++; if (acc_cnt - a0 != 1) begin bad++; $display("FAIL basic_acc got=%0d want=1", acc_cnt - a0); end
    total++; if (wgt_obs.size() != 8) begin bad++; $display("FAIL basic_wgt_n got=%0d want=8", wgt_obs.size()); end
    foreach (wgt_obs[k]) begin
      total++; if (wgt_obs[k].a !== 16'(k)) begin bad++; $display("FAIL basic_wgt_addr got=%0d want=%0d", wgt_obs[k].a, k); end
    end
    total++; if (act_obs.size() != 4) begin bad++; $display("FAIL basic_act_n got=%0d want=4", act_obs.size()); end
    foreach (act_obs[k]) begin
      total++; if (act_obs[k].a !== 16'(k)) begin bad++; $display("FAIL basic_act_addr got=%0d want=%0d", act_obs[k].a, k); end
    end
    while (wgt_exp.size() > 0 && wgt_obs.size() > 0) begin
      e = wgt_exp.pop_front(); o = wgt_obs.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL basic_wgt got=%h want=%h", o, e); end
    end
    while (act_exp.size() > 0 && act_obs.size() > 0) begin
      e = act_exp.pop_front(); o = act_obs.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL basic_act got=%h want=%h", o, e); end
    end
    total++; if (ofm_obs.size() != 3) begin bad++; $display("FAIL basic_ofm_n got=%0d want=3", ofm_obs.size()); end
    while (ofm_exp.size() > 0 && ofm_obs.size() > 0) begin
      eb = ofm_exp.pop_front(); ob = ofm_obs.pop_front();
      total++; if (ob !== eb) begin bad++; $display("FAIL basic_ofm got=%h want=%h", ob, eb); end
    end
    total++; if (comp_addr !== eng_act_addr) begin bad++; $display("FAIL basic_eng_mux got=%h want=%h", comp_addr, eng_act_addr); end
  endtask

  task automatic test_backpressure;
    bit ok; logic [63:0] eb, ob; int s0 = stall_seen, b0 = stall_bad;
    for (int k = 0; k < 1024; k++) act_mem[k] = k;
    wr_mode = 1;
    run_seq(0, 0, 3, 0, ok);
    wr_mode = 0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_done got=%0d want=1", ok); end
    total++; if (ofm_obs.size() != 3) begin bad++; $display("FAIL bp_n got=%0d want=3", ofm_obs.size()); end
    foreach (ofm_obs[k]) begin
      total++; if (ofm_obs[k] !== {32'(2*k+1), 32'(2*k)})
        begin bad++; $display("FAIL bp_beat got=%h want=%h", ofm_obs[k], {32'(2*k+1), 32'(2*k)}); end
    end
    while (ofm_exp.size() > 0 && ofm_obs.size() > 0) begin
      eb = ofm_exp.pop_front(); ob = ofm_obs.pop_front();
      total++; if (ob !== eb) begin bad++; $display("FAIL bp_sb got=%h want=%h", ob, eb); end
    end
    total++; if (stall_seen == s0) begin bad++; $display("FAIL bp_stalls got=0 want=>0"); end
    total++; if (stall_bad != b0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stall_bad - b0); end
  endtask

  task automatic test_throughput;
    bit ok; logic [63:0] eb, ob;
    run_seq(0, 0, 8, 16'd100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL tp_done got=%0d want=1", ok); end
    total++; if (ofm_cyc.size() != 8) begin bad++; $display("FAIL tp_n got=%0d want=8", ofm_cyc.size()); end
    foreach (ofm_cyc[k]) begin
      total++; if (ofm_cyc[k] != first_wv + k) begin bad++; $display("FAIL tp_cycle got=%0d want=%0d", ofm_cyc[k], first_wv + k); end
    end
    while (ofm_exp.size() > 0 && ofm_obs.size() > 0) begin
      eb = ofm_exp.pop_front(); ob = ofm_obs.pop_front();
      total++; if (ob !== eb) begin bad++; $display("FAIL tp_sb got=%h want=%h", ob, eb); end
    end
  endtask

  task automatic test_skip;
    bit ok; int v0 = rd_ctrl_vis;
    run_seq(0, 0, 1, 0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL skip_done got=%0d want=1", ok); end
    total++; if (rd_ctrl_vis != v0) begin bad++; $display("FAIL skip_rd_ctrl got=%0d want=0", rd_ctrl_vis - v0); end
    total++; if (comp_first < 0 || comp_first - conf_cyc > 3 || comp_first <= conf_cyc)
      begin bad++; $display("FAIL skip_latency got=%0d want=<=3", comp_first - conf_cyc); end
  endtask

  task automatic test_reset_mid;
    bit ok, found = 0; int a0; wr_t e, o; logic [63:0] eb, ob;
    cfg_wgt_len = 2; cfg_ifm_len = 3; cfg_ofm_len = 2; cfg_ofm_base = 0;
    @(negedge clk); conf_done = 1;
    @(negedge clk); conf_done = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = rd_idx == IFM_IDX && rd_beat == 1 && rd_left > 0;
    end
    total++; if (!found) begin bad++; $display("FAIL mid_reach got=0 want=1"); end
    rst = 0;
    @(negedge clk);
    total++; if ({dma_read_ctrl_valid, dma_write_ctrl_valid, dma_write_chnl_valid, dma_read_chnl_ready, compute_start, acc_done} !== 6'b0)
      begin bad++; $display("FAIL mid_valids got=%b want=0", {dma_read_ctrl_valid, dma_write_ctrl_valid, dma_write_chnl_valid, dma_read_chnl_ready, compute_start, acc_done}); end
    total++; if (debug !== 32'h0) begin bad++; $display("FAIL mid_debug got=%h want=0", debug); end
    rst = 1;
    a0 = acc_cnt;
    run_seq(2, 2, 2, 0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_rerun got=%0d want=1", ok); end
    total++; if (acc_cnt - a0 != 1) begin bad++; $display("FAIL mid_acc got=%0d want=1", acc_cnt - a0); end
    total++; if (wgt_obs.size() != 4 || act_obs.size() != 4 || ofm_obs.size() != 2)
      begin bad++; $display("FAIL mid_counts got=%0d/%0d/%0d want=4/4/2", wgt_obs.size(), act_obs.size(), ofm_obs.size()); end
    while (wgt_exp.size() > 0 && wgt_obs.size() > 0) begin
      e = wgt_exp.pop_front(); o = wgt_obs.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL mid_wgt got=%h want=%h", o, e); end
    end
    while (act_exp.size() > 0 && act_obs.size() > 0) begin
      e = act_exp.pop_front(); o = act_obs.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL mid_act got=%h want=%h", o, e); end
    end
    while (ofm_exp.size() > 0 && ofm_obs.size() > 0) begin
      eb = ofm_exp.pop_front(); ob = ofm_obs.pop_front();
      total++; if (ob !== eb) begin bad++; $display("FAIL mid_ofm got=%h want=%h", ob, eb); end
    end
  endtask

`ifdef WGT_CACHE_EN
  task automatic test_wgt_cache;
    bit ok; int h0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    cfg_wgt_reload = 0;
    h0 = wgt_hs;
    run_seq(2, 1, 1, 0, ok);
    total++; if (ok !== 1'b1 || wgt_hs - h0 != 1) begin bad++; $display("FAIL cache_first got=%0d want=1", wgt_hs - h0); end
    h0 = wgt_hs;
    run_seq(2, 1, 1, 0, ok);
    total++; if (ok !== 1'b1 || wgt_hs != h0) begin bad++; $display("FAIL cache_second got=%0d want=0", wgt_hs - h0); end
    total++; if (wgt_obs.size() != 0) begin bad++; $display("FAIL cache_wgt_writes got=%0d want=0", wgt_obs.size()); end
    cfg_wgt_reload = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_throughput();
    test_skip();
    test_reset_mid();
`ifdef WGT_CACHE_EN
    test_wgt_cache();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
